// File: rtl/fet_pkg.sv
// rtl/fet_pkg.sv - shared types, constants and J-immediate decode for the fetch queue
// Contents:
//   NOP_INST    instruction presented on the head fields when the queue is empty
//   OPC_JAL     major opcode of JAL, used by the optional predecoder
//   fet_entry_t one queue entry {inst, pc, nxt_pc, pred}
//   jal_imm()   sign-extended J-type immediate of an instruction word
package fet_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000033;
    localparam logic [6:0]  OPC_JAL  = 7'b1101111;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] nxt_pc;
        logic        pred;
    } fet_entry_t;

    // J-type immediate: imm[20|10:1|11|19:12] lives in inst[31:12]; bit 0 is always zero.
    function automatic logic [31:0] jal_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fet_fifo.sv
// rtl/fet_fifo.sv - generic synchronous FIFO with clear, push/pop and occupancy count
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   clr    in   synchronous flush: empties the FIFO and zeroes both pointers
//   push   in   write din at the tail (caller guarantees not full unless popping)
//   din    in   WIDTH-bit write data
//   pop    in   retire the head entry (caller guarantees not empty)
//   dout   out  head entry, read straight from storage (no same-cycle bypass)
//   count  out  occupancy, 0..DEPTH
module fet_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // Storage needs no reset: count gates every use of its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fet_qbuf.sv
// rtl/fet_qbuf.sv - fetch stage: PC generation plus a DEPTH-entry instruction queue to decode
// Optional feature macro: FET_QBUF_PREDECODE_EN (JAL predecode and static taken prediction).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_redir, i_redir_pc redirect/flush request and its target (low two bits dropped)
//   i_halt              stop issuing fetches; queued entries still drain
//   o_imem_raddr        fetch address (the PC register)
//   i_imem_rdata        instruction word for o_imem_raddr, same cycle
//   o_vld, i_rdy        head valid / decode accepts head
//   o_inst, o_pc        head instruction (NOP when empty) and its PC
//   o_nxt_pc, o_pred    head fall-through or predicted next PC, predicted-taken flag
//   o_flush             registered copy of i_redir for downstream squash
//   o_count             queue occupancy
module fet_qbuf
    import fet_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int          DEPTH      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_redir,
    input  logic [31:0]                  i_redir_pc,
    input  logic                         i_halt,
    output logic [31:0]                  o_imem_raddr,
    input  logic [31:0]                  i_imem_rdata,
    output logic                         o_vld,
    input  logic                         i_rdy,
    output logic [31:0]                  o_inst,
    output logic [31:0]                  o_pc,
    output logic [31:0]                  o_nxt_pc,
    output logic                         o_pred,
    output logic                         o_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   pc;
    logic [31:0]   npc;
    logic          pred;
    logic          push;
    logic          pop;
    logic          full;
    logic          vld;
    logic [CW-1:0] count;
    logic          flush;
    fet_entry_t    wr_entry;
    fet_entry_t    head;

    assign full = (count == CW'(DEPTH));
    assign vld  = (count != '0);

    // A redirect suppresses both sides; a pop frees the slot the push needs when full.
    assign pop  = vld & i_rdy & ~i_redir;
    assign push = ~i_redir & ~i_halt & (~full | pop);

    always_comb begin
        npc  = pc + 32'd4;
        pred = 1'b0;
`ifdef FET_QBUF_PREDECODE_EN
        if (i_imem_rdata[6:0] == OPC_JAL) begin
            npc  = pc + jal_imm(i_imem_rdata);
            pred = 1'b1;
        end
`endif
    end

    assign wr_entry = '{inst: i_imem_rdata, pc: pc, nxt_pc: npc, pred: pred};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc    <= RESET_ADDR;
            flush <= 1'b0;
        end else begin
            flush <= i_redir;
            if (i_redir) begin
                pc <= {i_redir_pc[31:2], 2'b00};
            end else if (push) begin
                pc <= npc;
            end
        end
    end

    fet_fifo #(
        .WIDTH ($bits(fet_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (i_redir),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    assign o_imem_raddr = pc;
    assign o_vld        = vld;
    assign o_inst       = vld ? head.inst   : NOP_INST;
    assign o_pc         = vld ? head.pc     : 32'd0;
    assign o_nxt_pc     = vld ? head.nxt_pc : 32'd0;
    assign o_pred       = vld & head.pred;
    assign o_flush      = flush;
    assign o_count      = count;

endmodule
